// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults and pixel format.
// Imported by the timing generator and the frame reader.
package vga_timing_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned H_TOTAL_DEF  =
      H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;
   localparam int unsigned V_TOTAL_DEF  =
      V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam int unsigned R_W   = 4;
   localparam int unsigned G_W   = 4;
   localparam int unsigned B_W   = 4;
   localparam int unsigned RGB_W = R_W + G_W + B_W;

   // Control bits that travel alongside a pixel fetch.
   // Sync bits are kept active-high here; polarity is
   // applied only at the pins.
   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic fs;
   } vga_ctl_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters for VGA raster timing.
// Produces active window, in-window sync flags and frame strobes.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF
) (
   input  logic pclk,
   input  logic rst,
   output logic active,
   output logic hsync_win,
   output logic vsync_win,
   output logic frame_end,
   output logic frame_first
);

   localparam int unsigned H_TOTAL =
      H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL =
      V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW = $clog2(H_TOTAL);
   localparam int unsigned VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_LO  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_HI  =
      HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] VS_LO  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_HI  =
      VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_last;
   logic          v_last;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   // Raster position: h wraps every line, v on the last pixel of each line.
   always_ff @(posedge pclk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Decodes of the registered position (stage 0 of the output pipe).
   always_comb begin
      active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hsync_win   = (h_cnt >= HS_LO) && (h_cnt < HS_HI);
      vsync_win   = (v_cnt >= VS_LO) && (v_cnt < VS_HI);
      frame_end   = h_last && v_last;
      frame_first = (h_cnt == '0) && (v_cnt == '0);
   end

endmodule

// File: rtl/vga_frame_reader.sv
// Frame-buffer reader driving VGA pins from linear RGB444 memory.
// Fetch address, bank latch and RAM-latency alignment of sync/DE.
module vga_frame_reader
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter bit          SYNC_POL = 1'b0,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned AW       = 19
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             bank_sel,
   output logic             ram_rd_en,
   output logic [AW-1:0]    ram_rd_addr,
   output logic             ram_rd_bank,
   input  logic [RGB_W-1:0] ram_rd_data,
   output logic             vga_hsync,
   output logic             vga_vsync,
   output logic             vga_de,
   output logic [RGB_W-1:0] vga_rgb,
   output logic             frame_start
);

   logic     active;
   logic     hsync_win;
   logic     vsync_win;
   logic     frame_end;
   logic     frame_first;
   vga_ctl_t ctl_s0;
   vga_ctl_t dly [RD_LAT];
   vga_ctl_t ctl_out;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .pclk        (pclk),
      .rst         (rst),
      .active      (active),
      .hsync_win   (hsync_win),
      .vsync_win   (vsync_win),
      .frame_end   (frame_end),
      .frame_first (frame_first)
   );

   assign ram_rd_en = active && !rst;

   // Linear fetch address: advances per active pixel, rewinds at frame end.
   always_ff @(posedge pclk) begin
      if (rst) begin
         ram_rd_addr <= '0;
      end else if (frame_end) begin
         ram_rd_addr <= '0;
      end else if (active) begin
         ram_rd_addr <= ram_rd_addr + 1'b1;
      end
   end

   // Displayed bank only switches between frames to avoid tearing.
   always_ff @(posedge pclk) begin
      if (rst) begin
         ram_rd_bank <= 1'b0;
      end else if (frame_end) begin
         ram_rd_bank <= bank_sel;
      end
   end

   // Stage-0 control bundle entering the latency-matching delay line.
   always_comb begin
      ctl_s0    = '0;
      ctl_s0.de = active;
      ctl_s0.hs = hsync_win;
      ctl_s0.vs = vsync_win;
      ctl_s0.fs = frame_first;
   end

   // Delay control by RD_LAT so it lines up with returning RAM data.
   always_ff @(posedge pclk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            dly[i] <= '0;
         end
      end else begin
         dly[0] <= ctl_s0;
         for (int i = 1; i < RD_LAT; i++) begin
            dly[i] <= dly[i-1];
         end
      end
   end

   assign ctl_out = dly[RD_LAT-1];

   // Pin registers: syncs get polarity, RGB is forced black in blanking.
   always_ff @(posedge pclk) begin
      if (rst) begin
         vga_hsync   <= ~SYNC_POL;
         vga_vsync   <= ~SYNC_POL;
         vga_de      <= 1'b0;
         vga_rgb     <= '0;
         frame_start <= 1'b0;
      end else begin
         vga_hsync   <= ctl_out.hs ? SYNC_POL : ~SYNC_POL;
         vga_vsync   <= ctl_out.vs ? SYNC_POL : ~SYNC_POL;
         vga_de      <= ctl_out.de;
         vga_rgb     <= ctl_out.de ? ram_rd_data : '0;
         frame_start <= ctl_out.fs;
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a reduced raster.
// Three instances cover RD_LAT = 1, 2 and 3.
module tb_vga_frame_reader;

   localparam int HA = 16;
   localparam int HF = 4;
   localparam int HS = 8;
   localparam int HB = 4;
   localparam int VA = 12;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FR = HT * VT;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic fs;
      logic [18:0] addr;
   } exp_t;

   logic pclk;
   logic rst;
   logic bank_sel;

   logic        u0_en, u1_en, u2_en;
   logic [18:0] u0_addr, u1_addr, u2_addr;
   logic        u0_bank, u1_bank, u2_bank;
   logic [11:0] ram0;
   logic [11:0] ram_w;
   logic        u0_hs, u1_hs, u2_hs;
   logic        u0_vs, u1_vs, u2_vs;
   logic        u0_de, u1_de, u2_de;
   logic [11:0] u0_rgb, u1_rgb, u2_rgb;
   logic        u0_fs, u1_fs, u2_fs;

   exp_t hist[$];
   int   n_chk;
   int   n_err;
   int   cyc;
   int   mh, mv, maddr;
   logic mbank;
   logic prev_rst, prev_bank;
   int   run [3];
   logic pde [3];
   int   last_fs;

   assign ram_w = 12'hFFF;

   vga_frame_reader #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .RD_LAT(1), .AW(19)
   ) u0 (
      .pclk(pclk), .rst(rst), .bank_sel(bank_sel),
      .ram_rd_en(u0_en), .ram_rd_addr(u0_addr),
      .ram_rd_bank(u0_bank), .ram_rd_data(ram0),
      .vga_hsync(u0_hs), .vga_vsync(u0_vs),
      .vga_de(u0_de), .vga_rgb(u0_rgb),
      .frame_start(u0_fs)
   );

   vga_frame_reader #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .RD_LAT(2), .AW(19)
   ) u1 (
      .pclk(pclk), .rst(rst), .bank_sel(bank_sel),
      .ram_rd_en(u1_en), .ram_rd_addr(u1_addr),
      .ram_rd_bank(u1_bank), .ram_rd_data(ram_w),
      .vga_hsync(u1_hs), .vga_vsync(u1_vs),
      .vga_de(u1_de), .vga_rgb(u1_rgb),
      .frame_start(u1_fs)
   );

   vga_frame_reader #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SYNC_POL(1'b0), .RD_LAT(3), .AW(19)
   ) u2 (
      .pclk(pclk), .rst(rst), .bank_sel(bank_sel),
      .ram_rd_en(u2_en), .ram_rd_addr(u2_addr),
      .ram_rd_bank(u2_bank), .ram_rd_data(ram_w),
      .vga_hsync(u2_hs), .vga_vsync(u2_vs),
      .vga_de(u2_de), .vga_rgb(u2_rgb),
      .frame_start(u2_fs)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   function automatic logic [11:0] pix(input int a);
      return 12'((a * 37) ^ 32'h5A5);
   endfunction

   // One-cycle RAM; junk during blanking must never reach the pins.
   always @(posedge pclk)
      ram0 <= u0_en ? pix(int'(u0_addr)) : 12'hBAD;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                  tag, cyc, got, exp);
      end
   endtask

   task automatic lane_chk(input string nm, input exp_t e,
                           input bit use_pix,
                           input logic de, input logic hs,
                           input logic vs, input logic fs,
                           input logic [11:0] rgb);
      logic [11:0] px;
      px = use_pix ? pix(int'(e.addr)) : 12'hFFF;
      check({nm, ".de"}, 32'(de), 32'(e.de));
      check({nm, ".hs"}, 32'(hs), 32'(!e.hs));
      check({nm, ".vs"}, 32'(vs), 32'(!e.vs));
      check({nm, ".fs"}, 32'(fs), 32'(e.fs));
      check({nm, ".rgb"}, 32'(rgb),
            32'(e.de ? px : 12'h000));
   endtask

   task automatic de_run(input int k, input logic de);
      if (de) begin
         run[k]++;
      end else begin
         if (pde[k] && run[k] > 0)
            check($sformatf("de_width%0d", k), run[k], HA);
         run[k] = 0;
      end
      pde[k] = de;
   endtask

   task automatic step(input logic r, input logic b);
      exp_t e;
      bit   act;
      int   n;
      @(posedge pclk);
      cyc++;
      if (prev_rst) begin
         mh = 0; mv = 0; maddr = 0; mbank = 1'b0;
      end else begin
         if (mh == HT-1 && mv == VT-1) begin
            maddr = 0;
            mbank = prev_bank;
         end else if (mh < HA && mv < VA) begin
            maddr++;
         end
         if (mh == HT-1) begin
            mh = 0;
            mv = (mv == VT-1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
      end
      #1;
      rst = r;
      bank_sel = b;
      #1;
      act = (mh < HA) && (mv < VA);
      check("rd_en", 32'(u0_en), 32'(act && !r));
      check("rd_en2", 32'(u1_en), 32'(act && !r));
      check("rd_en3", 32'(u2_en), 32'(act && !r));
      check("rd_addr", 32'(u0_addr), maddr);
      check("rd_addr2", 32'(u1_addr), maddr);
      check("rd_addr3", 32'(u2_addr), maddr);
      check("rd_bank", 32'(u0_bank), 32'(mbank));
      check("rd_bank2", 32'(u1_bank), 32'(mbank));
      check("rd_bank3", 32'(u2_bank), 32'(mbank));
      if (mh == HA-1 && mv == VA-1)
         check("last_addr", 32'(u0_addr), HA*VA-1);
      e.de   = act;
      e.hs   = (mh >= HA+HF) && (mh < HA+HF+HS);
      e.vs   = (mv >= VA+VF) && (mv < VA+VF+VS);
      e.fs   = (mh == 0) && (mv == 0);
      e.addr = 19'(maddr);
      hist.push_back(e);
      n = hist.size();
      if (n > 2)
         lane_chk("lat1", hist[n-3], 1'b1,
                  u0_de, u0_hs, u0_vs, u0_fs, u0_rgb);
      if (n > 3)
         lane_chk("lat2", hist[n-4], 1'b0,
                  u1_de, u1_hs, u1_vs, u1_fs, u1_rgb);
      if (n > 4)
         lane_chk("lat3", hist[n-5], 1'b0,
                  u2_de, u2_hs, u2_vs, u2_fs, u2_rgb);
      de_run(0, u0_de);
      de_run(1, u1_de);
      de_run(2, u2_de);
      if (u0_fs) begin
         if (last_fs >= 0)
            check("fs_period", cyc - last_fs, FR);
         last_fs = cyc;
      end
      if (r) begin
         hist.delete();
         for (int i = 0; i < 5; i++) hist.push_back('0);
         for (int k = 0; k < 3; k++) run[k] = -100000;
         last_fs = -1;
      end
      while (hist.size() > 6) void'(hist.pop_front());
      prev_rst  = r;
      prev_bank = b;
   endtask

   initial begin
      n_chk = 0; n_err = 0; cyc = 0;
      rst = 1'b1; bank_sel = 1'b0;
      prev_rst = 1'b1; prev_bank = 1'b0;
      mh = 0; mv = 0; maddr = 0; mbank = 1'b0;
      last_fs = -1;
      for (int k = 0; k < 3; k++) begin
         run[k] = -100000;
         pde[k] = 1'b0;
      end

      repeat (3) step(1'b1, 1'b0);
      repeat (2*FR + 50) step(1'b0, 1'b0);

      for (int i = 0; i < FR; i++) begin
         if (mv == 5 && mh == 0) break;
         step(1'b0, 1'b0);
      end
      repeat (2*FR) step(1'b0, 1'b1);

      for (int i = 0; i < FR; i++) begin
         if (mv == 5 && mh == 8) break;
         step(1'b0, 1'b1);
      end
      repeat (2) step(1'b1, 1'b1);
      repeat (2*FR + 20) step(1'b0, 1'b1);

      for (int i = 0; i < FR; i++) begin
         if (mv == 3 && mh == 0) break;
         step(1'b0, 1'b1);
      end
      repeat (FR + 40) step(1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
